jtag_mem_bridge: RTL and testbench
==================================

// Module: jtag_mem_bridge
// PURPOSE
//  Memory-side stage behind the JTAG USER1 data-register logic. Converts its 64-bit word
//  interface (WREN/ADDR/TO_MEM -> FROM_MEM) into single-outstanding 32-bit req/gnt/rvalid
//  transactions on a slow memory port. Reads of the addressed word are prefetched so
//  FROM_MEM is stable before the next CAPTURE. Clocked on the buffered TAP clock.
// PARAMETERS
//  ADDR_W   32   memory byte-address width; byte addr = {ADDR,3'b000} truncated to ADDR_W
//  TIMEOUT  255  max cycles waiting for MEM_GNT or MEM_RVALID before abort (1..65535)
// PORTS
//  TCK        in   1       single clock, rising edge
//  RESET      in   1       asynchronous, active-high reset
//  WREN       in   1       write strobe, one-cycle pulse per 64-bit write
//  ADDR       in   32      64-bit word index, level-sampled
//  TO_MEM     in   64      write data, valid when WREN=1
//  FROM_MEM   out  64      last completed read of ADDR
//  FROM_VALID out  1       FROM_MEM matches current ADDR and no access pending
//  BUSY       out  1       FSM not in IDLE or write pending
//  ERR        out  1       sticky: timeout occurred; cleared only by RESET
//  OVERRUN    out  1       sticky: WREN dropped (pending buffer full); cleared only by RESET
//  MEM_REQ    out  1       request; held with ADDR/WE/WDATA stable until MEM_GNT
//  MEM_WE     out  1       1=write beat, 0=read beat
//  MEM_ADDR   out  ADDR_W  byte address (low beat +0, high beat +4)
//  MEM_WDATA  out  32      write data (low beat TO_MEM[31:0], high beat [63:32])
//  MEM_GNT    in   1       accepts request in the cycle MEM_REQ&MEM_GNT
//  MEM_RVALID in   1       read data valid; earliest one cycle after accepting GNT
//  MEM_RDATA  in   32      read data
// BEHAVIOUR
//  Reset: all outputs 0; last_addr=0; refresh=1 (forces first read); pending empty; FSM=IDLE.
//   Async assertion mid-transaction drops MEM_REQ immediately; the memory beat is abandoned.
//  FSM: IDLE, WR_LO, WR_HI, RD_LO, RD_LO_W, RD_HI, RD_HI_W.
//  IDLE priority: pending write (or WREN this cycle) > read trigger > stay.
//   Write: latch ADDR/TO_MEM -> WR_LO; MEM_REQ=1, WE=1 at the following edge.
//   Read trigger: ADDR!=last_addr or refresh=1 -> latch ADDR -> RD_LO.
//  WR_LO --GNT--> WR_HI --GNT--> IDLE with refresh=1 (readback of written word follows).
//  RD_LO --GNT--> RD_LO_W --RVALID--> capture lo, RD_HI --GNT--> RD_HI_W --RVALID-->
//   FROM_MEM={rdata,lo} in one update (never half-updated); last_addr=latched addr;
//   refresh=0; IDLE.
//  FROM_VALID=1 only in IDLE, pending empty, refresh=0, ADDR==last_addr. ADDR change
//   drops it combinationally in the same cycle.
//  ADDR change during a read: current read completes and updates FROM_MEM/last_addr;
//   mismatch then retriggers a read from IDLE. No mid-read abort.
//  WREN while BUSY: captured into 1-deep pending buffer (addr+data). WREN while buffer full:
//   write discarded, OVERRUN<=1. Pending write starts on the next IDLE cycle, before reads.
//  Timeout: counter reloads on every state entry and counts cycles in REQ/W states; reaching
//   TIMEOUT -> MEM_REQ=0, ERR<=1, IDLE. On read abort FROM_MEM=64'hDEADBEEF_DEADBEEF,
//   last_addr=latched addr, refresh=0. On write abort refresh=1. MEM_RVALID outside *_W
//   states is ignored.
//  Widths: MEM_ADDR = ({ADDR,3'b000} + 4*beat)[ADDR_W-1:0]; wraps silently, no carry out.
//  Latency (GNT and RVALID same-cycle-ready): read trigger to FROM_VALID = 5 TCK cycles.
// TESTING
//  Reset, memory word 0 = 64'h1122334455667788, ADDR=0 -> beats at 0x0,0x4;
//   FROM_MEM=64'h1122334455667788; FROM_VALID=1 five cycles after reset release.
//  WREN with ADDR=2, TO_MEM=64'hCAFEF00D_01234567 -> writes 0x01234567@0x10 then
//   0xCAFEF00D@0x14; readback follows; FROM_MEM=64'hCAFEF00D01234567.
//  Three WREN pulses within 2 cycles while BUSY -> first and second written in order;
//   third dropped; OVERRUN=1.
//  MEM_GNT held 0 with TIMEOUT=8 -> MEM_REQ falls after 8 cycles; ERR=1;
//   FROM_MEM=64'hDEADBEEFDEADBEEF; FSM returns to IDLE.
//  ADDR 1->5 during RD_HI_W -> FROM_MEM first shows word 1, then word 5; FROM_VALID=0
//   until word 5 completes.
//  RESET asserted during RD_LO_W -> MEM_REQ and all outputs 0 asynchronously; after release
//   a fresh read of ADDR starts.

Source files
------------

// File: rtl/jtag_mem_bridge_if.sv
// Signal bundle between the USER1 64-bit word port, the bridge and the slow 32-bit memory port.
// The master view belongs to the bridge; the slave view belongs to the TAP logic and the memory.
interface jtag_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              WREN;
  logic [31:0]       ADDR;
  logic [63:0]       TO_MEM;
  logic [63:0]       FROM_MEM;
  logic              FROM_VALID;
  logic              BUSY;
  logic              ERR;
  logic              OVERRUN;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic              MEM_GNT;
  logic              MEM_RVALID;
  logic [31:0]       MEM_RDATA;

  modport master (
    input  WREN, ADDR, TO_MEM, MEM_GNT, MEM_RVALID, MEM_RDATA,
    output FROM_MEM, FROM_VALID, BUSY, ERR, OVERRUN,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    output WREN, ADDR, TO_MEM, MEM_GNT, MEM_RVALID, MEM_RDATA,
    input  FROM_MEM, FROM_VALID, BUSY, ERR, OVERRUN,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/jtag_mem_bridge.sv
// Splits 64-bit USER1 word accesses into two single-outstanding 32-bit memory beats and keeps
// the word at ADDR prefetched so FROM_MEM is stable before the next CAPTURE.
module jtag_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               TCK,
  input logic               RESET,
  jtag_mem_bridge_if.master bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LO   = 3'd1,
    WR_HI   = 3'd2,
    RD_LO   = 3'd3,
    RD_LO_W = 3'd4,
    RD_HI   = 3'd5,
    RD_HI_W = 3'd6
  } state_t;

  localparam logic [15:0] LAST_TICK  = 16'(TIMEOUT - 1);
  localparam logic [63:0] ABORT_WORD = 64'hDEAD_BEEF_DEAD_BEEF;

  state_t            state_r;
  logic [31:0]       cur_addr_r;
  logic [31:0]       last_addr_r;
  logic [31:0]       pend_addr_r;
  logic [31:0]       lo_r;
  logic [63:0]       wdata_r;
  logic [63:0]       pend_data_r;
  logic [63:0]       from_mem_r;
  logic              pend_valid_r;
  logic              refresh_r;
  logic              err_r;
  logic              overrun_r;
  logic              req_r;
  logic              we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [15:0]       cnt_r;

  logic [31:0]       wr_addr_s;
  logic [63:0]       wr_data_s;
  logic              start_wr_s;
  logic              timeout_s;

  // Byte address of a beat; wraps silently at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [31:0] word, input logic hi);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'({word, 3'b000});
    return base + ADDR_W'({hi, 2'b00});
  endfunction

  // Source of the next write: a buffered write always drains before a fresh strobe
  always_comb begin
    if (pend_valid_r) begin
      wr_addr_s = pend_addr_r;
      wr_data_s = pend_data_r;
    end else begin
      wr_addr_s = bus.ADDR;
      wr_data_s = bus.TO_MEM;
    end
  end

  assign start_wr_s = pend_valid_r | bus.WREN;
  assign timeout_s  = (cnt_r == LAST_TICK);

  // Bridge FSM with pending-write buffer, timeout counter and registered memory-port outputs
  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      state_r      <= IDLE;
      cur_addr_r   <= 32'd0;
      last_addr_r  <= 32'd0;
      pend_addr_r  <= 32'd0;
      lo_r         <= 32'd0;
      wdata_r      <= 64'd0;
      pend_data_r  <= 64'd0;
      from_mem_r   <= 64'd0;
      pend_valid_r <= 1'b0;
      refresh_r    <= 1'b1;
      err_r        <= 1'b0;
      overrun_r    <= 1'b0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'd0;
      cnt_r        <= 16'd0;
    end else begin
      if ((state_r != IDLE) && bus.WREN) begin
        if (pend_valid_r) begin
          overrun_r <= 1'b1;
        end else begin
          pend_valid_r <= 1'b1;
          pend_addr_r  <= bus.ADDR;
          pend_data_r  <= bus.TO_MEM;
        end
      end
      case (state_r)
        IDLE: begin
          cnt_r <= 16'd0;
          if (start_wr_s) begin
            cur_addr_r  <= wr_addr_s;
            wdata_r     <= wr_data_s;
            req_r       <= 1'b1;
            we_r        <= 1'b1;
            mem_addr_r  <= beat_addr(wr_addr_s, 1'b0);
            mem_wdata_r <= wr_data_s[31:0];
            state_r     <= WR_LO;
            // The slot frees as the buffered write launches, so a same-cycle strobe refills it.
            if (pend_valid_r && bus.WREN) begin
              pend_addr_r <= bus.ADDR;
              pend_data_r <= bus.TO_MEM;
            end else begin
              pend_valid_r <= 1'b0;
            end
          end else if (refresh_r || (bus.ADDR != last_addr_r)) begin
            cur_addr_r  <= bus.ADDR;
            req_r       <= 1'b1;
            we_r        <= 1'b0;
            mem_addr_r  <= beat_addr(bus.ADDR, 1'b0);
            mem_wdata_r <= 32'd0;
            state_r     <= RD_LO;
          end
        end
        WR_LO, WR_HI: begin
          if (bus.MEM_GNT && (state_r == WR_LO)) begin
            mem_addr_r  <= beat_addr(cur_addr_r, 1'b1);
            mem_wdata_r <= wdata_r[63:32];
            cnt_r       <= 16'd0;
            state_r     <= WR_HI;
          end else if (bus.MEM_GNT || timeout_s) begin
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            refresh_r <= 1'b1;
            err_r     <= err_r | ~bus.MEM_GNT;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RD_LO, RD_HI: begin
          if (bus.MEM_GNT) begin
            req_r   <= 1'b0;
            cnt_r   <= 16'd0;
            state_r <= (state_r == RD_LO) ? RD_LO_W : RD_HI_W;
          end else if (timeout_s) begin
            req_r       <= 1'b0;
            err_r       <= 1'b1;
            from_mem_r  <= ABORT_WORD;
            last_addr_r <= cur_addr_r;
            refresh_r   <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        RD_LO_W, RD_HI_W: begin
          if (bus.MEM_RVALID && (state_r == RD_LO_W)) begin
            lo_r       <= bus.MEM_RDATA;
            req_r      <= 1'b1;
            mem_addr_r <= beat_addr(cur_addr_r, 1'b1);
            cnt_r      <= 16'd0;
            state_r    <= RD_HI;
          end else if (bus.MEM_RVALID || timeout_s) begin
            from_mem_r  <= bus.MEM_RVALID ? {bus.MEM_RDATA, lo_r} : ABORT_WORD;
            err_r       <= err_r | ~bus.MEM_RVALID;
            last_addr_r <= cur_addr_r;
            refresh_r   <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          req_r   <= 1'b0;
          we_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.FROM_MEM   = from_mem_r;
  assign bus.FROM_VALID = (state_r == IDLE) && !pend_valid_r && !refresh_r && (bus.ADDR == last_addr_r);
  assign bus.BUSY       = (state_r != IDLE) || pend_valid_r;
  assign bus.ERR        = err_r;
  assign bus.OVERRUN    = overrun_r;
  assign bus.MEM_REQ    = req_r;
  assign bus.MEM_WE     = we_r;
  assign bus.MEM_ADDR   = mem_addr_r;
  assign bus.MEM_WDATA  = mem_wdata_r;
endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Drives the bridge against a small memory with random grant/rvalid delays and compares
// FROM_MEM and the memory beat log with a word-level reference memory.
module tb_jtag_mem_bridge;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        TCK = 1'b0;
  logic        RESET;
  logic        fast;
  logic        stall;
  logic [31:0] coin;
  logic [1:0]  req_age;
  logic [1:0]  dsel;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rd_busy;
  logic [1:0]  rd_cnt;
  logic [31:0] rd_word;
  logic        mem_ready = 1'b0;
  logic [31:0] mem [0:127];
  logic [63:0] ref_mem [0:63];
  beat_t       log_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  jtag_mem_bridge_if #(.ADDR_W(32)) bus ();

  jtag_mem_bridge #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .TCK   (TCK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 TCK = ~TCK;

  function automatic logic [31:0] mem_word(input int i);
    if (i == 0) return 32'h5566_7788;
    if (i == 1) return 32'h1122_3344;
    return {16'hB000 + 16'(i), 16'h0F00 + 16'(i)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge TCK);
      if (bus.FROM_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_beat(input string tag, input logic we, input logic [31:0] addr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge TCK);
      if (bus.MEM_REQ && bus.MEM_GNT && (bus.MEM_WE == we) && (bus.MEM_ADDR == addr)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_beat_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_beat(input string tag, input int idx, input logic we,
                            input logic [31:0] addr, input logic [31:0] data, input bit chk_data);
    if (log_q.size() <= idx) begin
      check_eq({tag, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    end else begin
      check_eq({tag, "_addr"}, {31'd0, log_q[idx].we, log_q[idx].addr}, {31'd0, we, addr});
      if (chk_data) check_eq({tag, "_data"}, 64'(log_q[idx].data), 64'(data));
    end
  endtask

  // Memory port: random grant, bounded waits, read data 1..3 cycles after grant
  assign dsel           = fast ? 2'd0 : ((coin[1:0] == 2'd3) ? 2'd2 : coin[1:0]);
  assign bus.MEM_GNT    = bus.MEM_REQ && !stall && (fast || coin[2] || (req_age >= 2'd2));
  assign bus.MEM_RVALID = rvalid;
  assign bus.MEM_RDATA  = rdata;

  always @(posedge TCK) begin
    coin <= $urandom;
    if (bus.MEM_REQ && !bus.MEM_GNT) req_age <= (req_age == 2'd3) ? 2'd3 : req_age + 2'd1;
    else req_age <= 2'd0;
  end

  always @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rd_busy <= 1'b0;
      rd_cnt  <= 2'd0;
      if (!mem_ready) begin
        for (int i = 0; i < 128; i++) mem[i] <= mem_word(i);
        mem_ready <= 1'b1;
      end
    end else begin
      rvalid <= 1'b0;
      if (rd_busy) begin
        if (rd_cnt == 2'd0) begin
          rvalid  <= 1'b1;
          rdata   <= rd_word;
          rd_busy <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt - 2'd1;
        end
      end
      if (bus.MEM_REQ && bus.MEM_GNT) begin
        log_q.push_back('{we: bus.MEM_WE, addr: bus.MEM_ADDR, data: bus.MEM_WDATA});
        if (bus.MEM_WE) begin
          mem[bus.MEM_ADDR[8:2]] <= bus.MEM_WDATA;
        end else if (dsel == 2'd0) begin
          rvalid <= 1'b1;
          rdata  <= mem[bus.MEM_ADDR[8:2]];
        end else begin
          rd_busy <= 1'b1;
          rd_cnt  <= dsel - 2'd1;
          rd_word <= mem[bus.MEM_ADDR[8:2]];
        end
      end
    end
  end

  initial begin
    logic [63:0] w1;
    logic [63:0] w5;
    bit          saw_w1;
    bit          valid_with_w1;
    int          req_cycles;

    RESET = 1'b1; fast = 1'b1; stall = 1'b0; req_age = 2'd0;
    bus.WREN = 1'b0; bus.ADDR = 32'd0; bus.TO_MEM = 64'd0;
    for (int w = 0; w < 64; w++) ref_mem[w] = {mem_word(2 * w + 1), mem_word(2 * w)};

    // Reset values, then the first prefetch of word 0 and its latency
    repeat (3) @(posedge TCK);
    #1;
    check_eq("rst_ctrl", {58'd0, bus.MEM_REQ, bus.MEM_WE, bus.FROM_VALID, bus.BUSY, bus.ERR, bus.OVERRUN}, 64'd0);
    check_eq("rst_from_mem", bus.FROM_MEM, 64'd0);
    check_eq("rst_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
    @(negedge TCK);
    RESET = 1'b0;
    log_q.delete();
    repeat (4) @(posedge TCK);
    #1;
    check_eq("lat_4", 64'(bus.FROM_VALID), 64'd0);
    @(posedge TCK);
    #1;
    check_eq("lat_5", 64'(bus.FROM_VALID), 64'd1);
    check_eq("word0", bus.FROM_MEM, 64'h1122_3344_5566_7788);
    check_beat("w0_lo", 0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_beat("w0_hi", 1, 1'b0, 32'h4, 32'h0, 1'b0);

    // Single write to word 2 followed by its readback
    log_q.delete();
    @(posedge TCK); #1;
    bus.WREN = 1'b1; bus.ADDR = 32'd2; bus.TO_MEM = 64'hCAFE_F00D_0123_4567;
    @(posedge TCK); #1;
    bus.WREN = 1'b0;
    check_eq("busy_wr", 64'(bus.BUSY), 64'd1);
    ref_mem[2] = 64'hCAFE_F00D_0123_4567;
    wait_valid("wr2");
    check_beat("wr2_lo", 0, 1'b1, 32'h10, 32'h0123_4567, 1'b1);
    check_beat("wr2_hi", 1, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b1);
    check_beat("wr2_rb", 2, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("wr2_data", bus.FROM_MEM, 64'hCAFE_F00D_0123_4567);

    // Three back-to-back strobes: one launches, one is buffered, one overruns
    log_q.delete();
    @(posedge TCK); #1;
    bus.WREN = 1'b1; bus.ADDR = 32'd3; bus.TO_MEM = 64'hA3A3_0003_1111_0003;
    @(posedge TCK); #1;
    bus.ADDR = 32'd4; bus.TO_MEM = 64'hA4A4_0004_2222_0004;
    @(posedge TCK); #1;
    bus.ADDR = 32'd5; bus.TO_MEM = 64'hA5A5_0005_3333_0005;
    @(posedge TCK); #1;
    bus.WREN = 1'b0;
    ref_mem[3] = 64'hA3A3_0003_1111_0003;
    ref_mem[4] = 64'hA4A4_0004_2222_0004;
    wait_valid("ovr");
    check_eq("overrun", 64'(bus.OVERRUN), 64'd1);
    check_beat("ovr_w3lo", 0, 1'b1, 32'h18, 32'h1111_0003, 1'b1);
    check_beat("ovr_w3hi", 1, 1'b1, 32'h1C, 32'hA3A3_0003, 1'b1);
    check_beat("ovr_w4lo", 2, 1'b1, 32'h20, 32'h2222_0004, 1'b1);
    check_beat("ovr_w4hi", 3, 1'b1, 32'h24, 32'hA4A4_0004, 1'b1);
    check_beat("ovr_rd5", 4, 1'b0, 32'h28, 32'h0, 1'b0);
    check_eq("ovr_word5", bus.FROM_MEM, ref_mem[5]);

    // Randomized reads, single writes and buffered double writes with random memory delays
    fast = 1'b0;
    for (int it = 0; it < 40; it++) begin
      int          op;
      logic [31:0] a1;
      logic [31:0] a2;
      logic [63:0] d1;
      logic [63:0] d2;
      op = $urandom_range(2, 0);
      a1 = 32'($urandom_range(15, 0));
      a2 = 32'($urandom_range(15, 0));
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      @(posedge TCK); #1;
      bus.ADDR = a1;
      if (op != 0) begin
        bus.WREN = 1'b1; bus.TO_MEM = d1;
        ref_mem[a1[5:0]] = d1;
        if (op == 2) begin
          @(posedge TCK); #1;
          bus.ADDR = a2; bus.TO_MEM = d2;
          ref_mem[a2[5:0]] = d2;
        end
        @(posedge TCK); #1;
        bus.WREN = 1'b0;
      end
      wait_valid($sformatf("rand%0d", it));
      check_eq($sformatf("rand%0d_op%0d", it, op), bus.FROM_MEM, ref_mem[bus.ADDR[5:0]]);
    end
    check_eq("rand_no_err", 64'(bus.ERR), 64'd0);

    // Word index above the byte-address range aliases onto a low word
    log_q.delete();
    @(posedge TCK); #1;
    bus.WREN = 1'b1; bus.ADDR = 32'h2000_0003; bus.TO_MEM = 64'h0BAD_CAFE_1234_ABCD;
    @(posedge TCK); #1;
    bus.WREN = 1'b0;
    ref_mem[3] = 64'h0BAD_CAFE_1234_ABCD;
    wait_valid("alias_wr");
    check_beat("alias_lo", 0, 1'b1, 32'h18, 32'h1234_ABCD, 1'b1);
    @(posedge TCK); #1;
    bus.ADDR = 32'd3;
    wait_valid("alias_rd");
    check_eq("alias_data", bus.FROM_MEM, ref_mem[3]);
    log_q.delete();
    @(posedge TCK); #1;
    bus.ADDR = 32'hFFFF_FFFF;
    wait_valid("wrap");
    check_beat("wrap_lo", 0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
    check_beat("wrap_hi", 1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);

    // ADDR moves from 1 to 5 while the high beat of word 1 is outstanding
    fast = 1'b1;
    @(posedge TCK); #1;
    bus.ADDR = 32'd0;
    wait_valid("pre15");
    w1 = ref_mem[1];
    w5 = ref_mem[5];
    @(posedge TCK); #1;
    bus.ADDR = 32'd1;
    wait_beat("a15", 1'b0, 32'hC);
    @(posedge TCK); #1;
    bus.ADDR = 32'd5;
    saw_w1 = 1'b0;
    valid_with_w1 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge TCK);
      if (bus.FROM_MEM == w1) begin
        saw_w1 = 1'b1;
        if (bus.FROM_VALID) valid_with_w1 = 1'b1;
      end
      if (bus.FROM_VALID) break;
    end
    check_eq("a15_saw_w1", 64'(saw_w1), 64'd1);
    check_eq("a15_no_valid_w1", 64'(valid_with_w1), 64'd0);
    check_eq("a15_valid", 64'(bus.FROM_VALID), 64'd1);
    check_eq("a15_word5", bus.FROM_MEM, w5);

    // Grant withheld: the request is abandoned after TIMEOUT cycles
    check_eq("pre_to_err", 64'(bus.ERR), 64'd0);
    stall = 1'b1;
    @(posedge TCK); #1;
    bus.ADDR = 32'd7;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge TCK);
      if (bus.MEM_REQ) req_cycles++;
      else if (req_cycles > 0) break;
    end
    check_eq("to_req_cycles", 64'(req_cycles), 64'd8);
    check_eq("to_err", 64'(bus.ERR), 64'd1);
    check_eq("to_data", bus.FROM_MEM, 64'hDEAD_BEEF_DEAD_BEEF);
    check_eq("to_idle", {62'd0, bus.BUSY, bus.FROM_VALID}, 64'd1);
    stall = 1'b0;

    // Asynchronous reset in the middle of the low read beat, then a fresh read
    @(posedge TCK); #1;
    bus.ADDR = 32'd9;
    wait_beat("rst_mid", 1'b0, 32'h48);
    @(posedge TCK); #1;
    RESET = 1'b1;
    #1;
    check_eq("rst_mid_ctrl", {58'd0, bus.MEM_REQ, bus.MEM_WE, bus.FROM_VALID, bus.BUSY, bus.ERR, bus.OVERRUN}, 64'd0);
    check_eq("rst_mid_data", bus.FROM_MEM, 64'd0);
    @(negedge TCK);
    RESET = 1'b0;
    log_q.delete();
    @(negedge TCK);
    check_eq("rst_restart", {31'd0, bus.MEM_REQ, bus.MEM_ADDR}, {31'd0, 1'b1, 32'h48});
    wait_valid("rst_rd");
    check_eq("rst_word9", bus.FROM_MEM, ref_mem[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
